// File: rtl/player_controller.sv
// Per-frame player controller: consumes the sticky button event vector, moves/faces the player, runs attack FSM.
// One-cycle latency from frame_tick; define PLAYER_HOLD_REPEAT_EN for auto-repeat of a held direction.
module player_controller #(
  parameter int GRID_W          = 16,
  parameter int GRID_H          = 12,
  parameter int START_X         = 0,
  parameter int START_Y         = 0,
  parameter int ATTACK_FRAMES   = 4,
  parameter int COOLDOWN_FRAMES = 8,
  parameter int REPEAT_FRAMES   = 6
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      frame_tick,
  input  logic [9:0]                control_state,
  output logic                      events_ack,
  output logic [$clog2(GRID_W)-1:0] player_x,
  output logic [$clog2(GRID_H)-1:0] player_y,
  output logic [1:0]                player_dir,
  output logic                      attacking,
  output logic                      cooldown
);
  localparam int X_W     = $clog2(GRID_W);
  localparam int Y_W     = $clog2(GRID_H);
  localparam int CNT_MAX = (ATTACK_FRAMES > COOLDOWN_FRAMES) ? ATTACK_FRAMES : COOLDOWN_FRAMES;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int RPT_W   = (REPEAT_FRAMES > 1) ? $clog2(REPEAT_FRAMES) : 1;

  if (ATTACK_FRAMES < 1 || COOLDOWN_FRAMES < 1 || REPEAT_FRAMES < 1) begin : g_bad_params
    $error("player_controller: frame counts must be at least 1");
  end

  typedef enum logic [1:0] {S_IDLE, S_ATTACK, S_COOLDOWN} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [X_W-1:0]   x_q, x_d;
  logic [Y_W-1:0]   y_q, y_d;
  logic [1:0]       dir_q, dir_d;
  logic [4:0]       held_q, held_d;
  logic             ack_q, ack_d;
  logic [4:0]       pressed, released;
  logic             win_vld, mv_vld;
  logic [1:0]       win_dir, mv_dir;
`ifdef PLAYER_HOLD_REPEAT_EN
  logic [RPT_W-1:0] rpt_q, rpt_d;
  logic             hold_vld;
  logic [1:0]       hold_dir;
`endif

  assign pressed  = control_state[9:5];
  assign released = control_state[4:0];

  // Fixed priority up > down > left > right; bit index doubles as direction code.
  always_comb begin
    win_vld = 1'b1;
    win_dir = 2'd0;
    if (pressed[0])      win_dir = 2'd0;
    else if (pressed[1]) win_dir = 2'd1;
    else if (pressed[2]) win_dir = 2'd2;
    else if (pressed[3]) win_dir = 2'd3;
    else                 win_vld = 1'b0;
  end

`ifdef PLAYER_HOLD_REPEAT_EN
  always_comb begin
    hold_vld = 1'b1;
    hold_dir = 2'd0;
    if (held_q[0])      hold_dir = 2'd0;
    else if (held_q[1]) hold_dir = 2'd1;
    else if (held_q[2]) hold_dir = 2'd2;
    else if (held_q[3]) hold_dir = 2'd3;
    else                hold_vld = 1'b0;
  end
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    x_d     = x_q;
    y_d     = y_q;
    dir_d   = dir_q;
    held_d  = held_q;
    ack_d   = 1'b0;
    mv_vld  = 1'b0;
    mv_dir  = win_dir;
`ifdef PLAYER_HOLD_REPEAT_EN
    rpt_d   = rpt_q;
`endif
    if (frame_tick) begin
      ack_d  = 1'b1;
      held_d = (held_q | pressed) & ~released;
      if (win_vld) begin
        dir_d  = win_dir;
        mv_vld = 1'b1;
      end
`ifdef PLAYER_HOLD_REPEAT_EN
      // Any event restarts the repeat period; otherwise count while a direction is held.
      if (|control_state || !hold_vld) begin
        rpt_d = '0;
      end else if (rpt_q == RPT_W'(REPEAT_FRAMES - 1)) begin
        rpt_d  = '0;
        mv_vld = 1'b1;
        mv_dir = hold_dir;
      end else begin
        rpt_d = rpt_q + 1'b1;
      end
`endif
      unique case (state_q)
        S_IDLE: begin
          if (pressed[4]) begin
            state_d = S_ATTACK;
            cnt_d   = CNT_W'(ATTACK_FRAMES - 1);
            mv_vld  = 1'b0;
          end
        end
        S_ATTACK: begin
          mv_vld = 1'b0;
          if (cnt_q == '0) begin
            state_d = S_COOLDOWN;
            cnt_d   = CNT_W'(COOLDOWN_FRAMES - 1);
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        S_COOLDOWN: begin
          if (cnt_q == '0) state_d = S_IDLE;
          else             cnt_d   = cnt_q - 1'b1;
        end
        default: state_d = S_IDLE;
      endcase
      // Bounds are checked before stepping so the unsigned position never wraps.
      if (mv_vld) begin
        unique case (mv_dir)
          2'd0: if (y_q != '0)                   y_d = y_q - 1'b1;
          2'd1: if (y_q != Y_W'(GRID_H - 1))     y_d = y_q + 1'b1;
          2'd2: if (x_q != '0)                   x_d = x_q - 1'b1;
          default: if (x_q != X_W'(GRID_W - 1))  x_d = x_q + 1'b1;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      x_q     <= X_W'(START_X);
      y_q     <= Y_W'(START_Y);
      dir_q   <= 2'd0;
      held_q  <= '0;
      ack_q   <= 1'b0;
`ifdef PLAYER_HOLD_REPEAT_EN
      rpt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      x_q     <= x_d;
      y_q     <= y_d;
      dir_q   <= dir_d;
      held_q  <= held_d;
      ack_q   <= ack_d;
`ifdef PLAYER_HOLD_REPEAT_EN
      rpt_q   <= rpt_d;
`endif
    end
  end

  assign events_ack = ack_q;
  assign player_x   = x_q;
  assign player_y   = y_q;
  assign player_dir = dir_q;
  assign attacking  = (state_q == S_ATTACK);
  assign cooldown   = (state_q == S_COOLDOWN);
endmodule
